// File: rtl/neuron_core_pkg.sv
// Shared address map and FSM encoding for the neuron core and the initiators
// that drive it; the slave-side decoder imports the same region offsets.
package neuron_core_pkg;

  localparam logic [31:0] CORE_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] SYN_OFFSET     = 32'h0000_0000;
  localparam logic [31:0] PARAM_OFFSET   = 32'h0000_2000;
  localparam logic [31:0] SPIKE_OFFSET   = 32'h0000_4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_READ,
    ST_FINISH
  } state_t;

  typedef enum logic {
    PH_SYN,
    PH_PRM
  } phase_t;

  // Byte address of word idx inside a region of the core.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] offset,
                                            input logic [8:0]  idx);
    return base + offset + {21'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Per-transfer acknowledge watchdog; expired fires on the tick that brings
// the wait count up to LIMIT, so the owner can abort on that same edge.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  assign expired = tick && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/neuron_core_wb_loader.sv
// Wishbone classic initiator: streams synapse and parameter words from a
// valid/ready source into the neuron core, then reads back the spike word.
module neuron_core_wb_loader
  import neuron_core_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = CORE_BASE_ADDR,
  parameter int          SYN_WORDS   = 256,
  parameter int          PARAM_WORDS = 3,
  parameter int          TIMEOUT     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start,
  input  logic [31:0] cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] spike_data,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output state_t      dbg_state
);

  // Config source: a word moves on any rising edge where cfg_valid && cfg_ready;
  // cfg_ready is only offered in FETCH. Bus side: each transfer holds
  // cyc/stb/adr/dat/we stable until the edge that samples ack.
  localparam logic [8:0] SYN_LAST = 9'(SYN_WORDS - 1);
  localparam logic [8:0] PRM_LAST = 9'(PARAM_WORDS - 1);

  state_t     state;
  phase_t     phase;
  logic [8:0] idx;
  logic       waiting;
  logic       to_expired;

  assign waiting   = (state == ST_WRITE) || (state == ST_READ);
  assign dbg_state = state;

  // Any ack restarts the watchdog, so WRITE->READ starts the read at zero.
  wb_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (!waiting || wbm_ack_i),
    .tick    (waiting && !wbm_ack_i),
    .expired (to_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= ST_IDLE;
      phase      <= PH_SYN;
      idx        <= 9'd0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      spike_data <= 32'd0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'h0;
      wbm_adr_o  <= 32'd0;
      wbm_dat_o  <= 32'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            phase     <= PH_SYN;
            idx       <= 9'd0;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (cfg_valid) begin
            cfg_ready <= 1'b0;
            wbm_dat_o <= cfg_data;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= word_addr(BASE_ADDR,
                                   (phase == PH_SYN) ? SYN_OFFSET : PARAM_OFFSET, idx);
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            if (phase == PH_SYN && idx == SYN_LAST) begin
              phase     <= PH_PRM;
              idx       <= 9'd0;
              cfg_ready <= 1'b1;
              state     <= ST_FETCH;
            end else if (phase == PH_PRM && idx == PRM_LAST) begin
              // Read follows immediately as a fresh transfer on the same cycle.
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
              wbm_adr_o <= word_addr(BASE_ADDR, SPIKE_OFFSET, 9'd0);
              state     <= ST_READ;
            end else begin
              idx       <= idx + 9'd1;
              cfg_ready <= 1'b1;
              state     <= ST_FETCH;
            end
          end else if (to_expired) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (wbm_ack_i || to_expired) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'd0;
            busy      <= 1'b0;
            if (wbm_ack_i) begin
              spike_data <= wbm_dat_i;
              done       <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              error <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_core_wb_loader.sv
// Self-checking bench for neuron_core_wb_loader: random config words, a
// behavioural Wishbone slave, and a transfer-list reference model.
module tb_neuron_core_wb_loader;
  import neuron_core_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int SYN_N = 256;
  localparam int PRM_N = 3;
  localparam int TO    = 255;

  logic        clk, rst_n, start;
  logic [31:0] cfg_data;
  logic        cfg_valid, cfg_ready, busy, done, error;
  logic [31:0] spike_data;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  state_t      dbg_state;

  int vectors = 0;
  int miscompares = 0;

  bit          ack_force = 0;
  bit          stall_en = 0;
  logic [31:0] stall_addr = 32'd0;
  logic [31:0] spike_val = 32'd0;
  logic [31:0] last_spike = 32'd0;
  bit          src_rand = 0;
  bit          mon_en = 0;
  int          done_cnt = 0;
  int          error_cnt = 0;

  logic [31:0] sent_q[$];
  logic [64:0] log_q[$];
  logic [64:0] exp_q[$];

  neuron_core_wb_loader dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .start      (start),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .spike_data (spike_data),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave: zero-wait ack, optionally withheld on one write address.
  assign wbm_ack_i = ack_force ||
                     (wbm_cyc_o && wbm_stb_o && !(stall_en && wbm_we_o && wbm_adr_o == stall_addr));
  assign wbm_dat_i = spike_val;

  // Config word source; records every word the DUT takes, in order.
  initial begin
    bit accepted;
    accepted  = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (accepted) begin
        cfg_valid = 1'b0;
        accepted  = 1'b0;
      end
      if (!cfg_valid && (!src_rand || $urandom_range(0, 1) == 1)) begin
        cfg_data  = $urandom;
        cfg_valid = 1'b1;
      end
      if (cfg_valid && cfg_ready && rst_n) begin
        sent_q.push_back(cfg_data);
        accepted = 1'b1;
      end
    end
  end

  // Bus monitor: logs completed transfers and checks protocol invariants.
  initial begin
    logic        prev_hold;
    logic [64:0] prev_bus;
    prev_hold = 1'b0;
    prev_bus  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vectors++;
        if (wbm_sel_o !== (wbm_stb_o ? 4'hF : 4'h0)) begin
          miscompares++;
          $display("FAIL sel: got %h required %h", wbm_sel_o, wbm_stb_o ? 4'hF : 4'h0);
        end
        vectors++;
        if ((done && error) || (cfg_ready && wbm_cyc_o)) begin
          miscompares++;
          $display("FAIL exclusive: done=%b error=%b cfg_ready=%b cyc=%b required no overlap",
                   done, error, cfg_ready, wbm_cyc_o);
        end
        if (prev_hold && wbm_stb_o) begin
          vectors++;
          if ({wbm_we_o, wbm_adr_o, wbm_dat_o} !== prev_bus) begin
            miscompares++;
            $display("FAIL hold: got %h required %h", {wbm_we_o, wbm_adr_o, wbm_dat_o}, prev_bus);
          end
        end
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i)
          log_q.push_back({wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'd0});
        if (done) done_cnt++;
        if (error) error_cnt++;
      end
      prev_hold = wbm_stb_o && !wbm_ack_i;
      prev_bus  = {wbm_we_o, wbm_adr_o, wbm_dat_o};
    end
  end

  // Reference model: the ordered list of transfers a sequence must produce.
  function automatic void build_expected(input int n_writes, input bit with_read);
    exp_q.delete();
    for (int i = 0; i < n_writes; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = (i < SYN_N) ? BASE + 32'(4 * i) : BASE + 32'h2000 + 32'(4 * (i - SYN_N));
      d = (i < sent_q.size()) ? sent_q[i] : 32'hxxxx_xxxx;
      exp_q.push_back({1'b1, a, d});
    end
    if (with_read) exp_q.push_back({1'b0, BASE + 32'h4000, 32'd0});
  endfunction

  task automatic run_sequence(input logic [31:0] spike, input bit check_timing,
                              input int restart_at);
    int n;
    int first_cyc;
    bit got_done;
    n = 0;
    first_cyc = 0;
    got_done = 1'b0;
    spike_val = spike;
    @(posedge clk);
    #1;
    log_q.delete();
    sent_q.delete();
    done_cnt = 0;
    error_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
      if (first_cyc == 0 && wbm_cyc_o) first_cyc = n;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (error) break;
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL seq_done: no done after %0d cycles, required done", n);
    end
    if (check_timing) begin
      vectors++;
      if (n != 2 * (SYN_N + PRM_N) + 2) begin
        miscompares++;
        $display("FAIL seq_cycles: got %0d required %0d", n, 2 * (SYN_N + PRM_N) + 2);
      end
      vectors++;
      if (first_cyc != 2) begin
        miscompares++;
        $display("FAIL start_to_cyc: got cycle %0d required 2", first_cyc);
      end
    end
    vectors++;
    if (sent_q.size() != SYN_N + PRM_N) begin
      miscompares++;
      $display("FAIL words_taken: got %0d required %0d", sent_q.size(), SYN_N + PRM_N);
    end
    build_expected(SYN_N + PRM_N, 1'b1);
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL xfer_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL xfer[%0d]: got %h required %h", i,
                 (i < log_q.size()) ? log_q[i] : 65'h0, exp_q[i]);
      end
    end
    vectors++;
    if (spike_data !== spike || done_cnt != 1 || error_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_end: spike=%h done_cnt=%0d error_cnt=%0d busy=%b required %h 1 0 0",
               spike_data, done_cnt, error_cnt, busy, spike);
    end
    last_spike = spike;
  endtask

  task automatic test_reset();
    start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, cfg_ready, busy, done, error} !== 10'd0 ||
        wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 || spike_data !== 32'd0 ||
        dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_values: cyc=%b stb=%b adr=%h dat=%h spike=%h busy=%b state=%0d required 0/IDLE",
               wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_dat_o, spike_data, busy, dbg_state);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_sequence();
    src_rand = 1'b0;
    run_sequence(32'hDEAD_BEEF, 1'b1, 0);
  endtask

  task automatic test_random_valid();
    src_rand = 1'b1;
    run_sequence($urandom, 1'b0, 0);
    src_rand = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    int rise_at;
    int err_at;
    n = 0;
    rise_at = 0;
    err_at = 0;
    stall_en = 1'b1;
    stall_addr = BASE + 32'd20;
    spike_val = ~last_spike;
    @(posedge clk);
    #1;
    log_q.delete();
    sent_q.delete();
    done_cnt = 0;
    error_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (rise_at == 0 && wbm_stb_o && wbm_adr_o == stall_addr) rise_at = n;
      if (error) begin
        err_at = n;
        break;
      end
    end
    vectors++;
    if (err_at - rise_at != TO || rise_at == 0) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d (stb at %0d, error at %0d) required %0d",
               err_at - rise_at, rise_at, err_at, TO);
    end
    vectors++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_drop: cyc=%b stb=%b busy=%b required 0 0 0", wbm_cyc_o, wbm_stb_o, busy);
    end
    repeat (6) @(negedge clk);
    build_expected(5, 1'b0);
    vectors++;
    if (log_q.size() != 5 || sent_q.size() != 6) begin
      miscompares++;
      $display("FAIL timeout_xfers: got %0d xfers %0d words required 5 6", log_q.size(), sent_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL timeout_xfer[%0d]: got %h required %h", i,
                 (i < log_q.size()) ? log_q[i] : 65'h0, exp_q[i]);
      end
    end
    vectors++;
    if (spike_data !== last_spike || error_cnt != 1 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL timeout_end: spike=%h error_cnt=%0d done_cnt=%0d required %h 1 0",
               spike_data, error_cnt, done_cnt, last_spike);
    end
    stall_en = 1'b0;
  endtask

  task automatic test_double_start();
    run_sequence($urandom, 1'b1, 101);
  endtask

  task automatic test_reset_mid_prm();
    int n;
    n = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n < 2000 && !(wbm_cyc_o && wbm_we_o && wbm_adr_o == BASE + 32'h2004)) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL reach_prm: no PRM write after %0d cycles, required one", n);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: cyc=%b stb=%b busy=%b required 0 0 0", wbm_cyc_o, wbm_stb_o, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_spike = 32'd0;
    run_sequence($urandom, 1'b1, 0);
    vectors++;
    if (log_q.size() == 0 || log_q[0][63:32] !== BASE) begin
      miscompares++;
      $display("FAIL restart_addr: got %h required %h", (log_q.size() > 0) ? log_q[0][63:32] : 32'h0, BASE);
    end
  endtask

  task automatic test_ack_idle();
    ack_force = 1'b1;
    repeat (16) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || wbm_cyc_o !== 1'b0 || cfg_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
        miscompares++;
        $display("FAIL idle_ack: busy=%b cyc=%b cfg_ready=%b state=%0d required 0 0 0 IDLE",
                 busy, wbm_cyc_o, cfg_ready, dbg_state);
      end
    end
    run_sequence($urandom, 1'b1, 0);
    ack_force = 1'b0;
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_full_sequence();
    test_random_valid();
    test_timeout();
    test_double_start();
    test_reset_mid_prm();
    test_ack_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
